// File: rtl/lte_ul_path_pow_rd.sv
// Uplink power-detect result reader: triggers a capture, waits out the capture window,
// then reads the 160x32 result RAM and streams one saturated 64-bit power total per subframe.
module lte_ul_path_pow_rd #(
  parameter int          TRIG_HOLD = 4,
  parameter logic [31:0] WAIT_CYC  = 32'd300000000,
  parameter int          RD_LAT    = 2
) (
  input  logic        clk_apb,
  input  logic        asy_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [31:0] o_pd_trig,
  output logic [31:0] o_raddr,
  input  logic [31:0] i_rdata,
  output logic        o_sf_valid,
  input  logic        i_sf_ready,
  output logic [3:0]  o_sf_idx,
  output logic [63:0] o_sf_pow,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT, S_READ, S_OUT, S_DONE
  } state_t;

  state_t          state;
  logic [7:0]      trig_cnt;
  logic [31:0]     wait_cnt;
  logic [3:0]      sf;
  logic [4:0]      iss_cnt;
  logic [2:0]      hi_cnt;
  logic [31:0]     lo_word;
  logic [66:0]     acc, acc_nxt;
  logic [RD_LAT:0] vld_pipe, half_pipe;

  logic            xfer, wait_done, ret, last_ret;
  logic            issue, issue_half;
  logic [7:0]      issue_addr;

  // Entry into READ issues the first address on the same edge, so the 16
  // reads of a subframe land in the first 16 READ cycles with no bubble.
  always_comb begin
    xfer       = o_sf_valid & i_sf_ready;
    wait_done  = (state == S_WAIT) && (wait_cnt == WAIT_CYC - 32'd1);
    acc_nxt    = acc + {3'b000, i_rdata, lo_word};
    ret        = (state == S_READ) && vld_pipe[RD_LAT];
    last_ret   = ret && half_pipe[RD_LAT] && (hi_cnt == 3'd7);
    issue      = 1'b0;
    issue_half = 1'b0;
    issue_addr = 8'd0;
    if (!i_abort) begin
      case (state)
        S_WAIT: if (wait_done) issue = 1'b1;
        S_READ: if (iss_cnt < 5'd16) begin
          issue      = 1'b1;
          issue_half = iss_cnt[0];
          issue_addr = {sf, iss_cnt[3:0]};
        end
        S_OUT: if (xfer && sf != 4'd9) begin
          issue      = 1'b1;
          issue_addr = {sf + 4'd1, 4'd0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_apb or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state      <= S_IDLE;
      trig_cnt   <= '0;
      wait_cnt   <= '0;
      sf         <= '0;
      iss_cnt    <= '0;
      hi_cnt     <= '0;
      lo_word    <= '0;
      acc        <= '0;
      vld_pipe   <= '0;
      half_pipe  <= '0;
      o_pd_trig  <= '0;
      o_raddr    <= '0;
      o_sf_valid <= 1'b0;
      o_sf_idx   <= '0;
      o_sf_pow   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], issue};
      half_pipe <= {half_pipe[RD_LAT-1:0], issue_half};
      if (issue) o_raddr <= {24'd0, issue_addr};

      if (i_abort) begin
        // Flushing the tag pipe drops any read data still on its way back.
        state      <= S_IDLE;
        vld_pipe   <= '0;
        acc        <= '0;
        hi_cnt     <= '0;
        iss_cnt    <= '0;
        trig_cnt   <= '0;
        wait_cnt   <= '0;
        o_pd_trig  <= '0;
        o_sf_valid <= 1'b0;
        o_busy     <= 1'b0;
        o_done     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            o_done <= 1'b0;
            if (i_start) begin
              state     <= S_TRIG;
              trig_cnt  <= '0;
              o_pd_trig <= 32'd1;
              o_busy    <= 1'b1;
            end
          end
          S_TRIG: begin
            trig_cnt <= trig_cnt + 8'd1;
            if (trig_cnt == 8'(TRIG_HOLD - 1)) begin
              o_pd_trig <= '0;
              wait_cnt  <= '0;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            wait_cnt <= wait_cnt + 32'd1;
            if (wait_done) begin
              sf      <= '0;
              acc     <= '0;
              hi_cnt  <= '0;
              iss_cnt <= 5'd1;
              state   <= S_READ;
            end
          end
          S_READ: begin
            if (iss_cnt < 5'd16) iss_cnt <= iss_cnt + 5'd1;
            if (ret) begin
              if (half_pipe[RD_LAT]) begin
                acc    <= acc_nxt;
                hi_cnt <= hi_cnt + 3'd1;
              end else begin
                lo_word <= i_rdata;
              end
            end
            if (last_ret) begin
              o_sf_valid <= 1'b1;
              o_sf_idx   <= sf;
              o_sf_pow   <= (|acc_nxt[66:64]) ? 64'hFFFF_FFFF_FFFF_FFFF : acc_nxt[63:0];
              state      <= S_OUT;
            end
          end
          S_OUT: begin
            if (xfer) begin
              o_sf_valid <= 1'b0;
              if (sf == 4'd9) begin
                o_done <= 1'b1;
                state  <= S_DONE;
              end else begin
                sf      <= sf + 4'd1;
                acc     <= '0;
                hi_cnt  <= '0;
                iss_cnt <= 5'd1;
                state   <= S_READ;
              end
            end
          end
          S_DONE: begin
            o_done <= 1'b0;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
